pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised, elastic multi-stage pipeline register for the microProcessor datapath.
- Generalises the single reset flip-flop to DEPTH stages of WIDTH-bit data, each with a valid bit.
- Adds valid/ready backpressure, synchronous flush and an occupancy count.
- Sits between datapath sections (e.g. fetch→decode) where stalls and branch flushes must be absorbed without losing or duplicating words.

Parameters:
- WIDTH, 32, data width in bits (≥1).
- DEPTH, 2, number of register stages (≥1).
- RESET_VAL, 0, value loaded into every data register on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all in-flight words.
- in_valid  input  1  upstream word present.
- in_ready  output  1  chain accepts a word this cycle.
- in_data  input  WIDTH  upstream word.
- out_valid  output  1  last stage holds a valid word.
- out_ready  input  1  downstream consumes this cycle.
- out_data  output  WIDTH  last-stage word.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset (async, active-high): all valid bits 0; all data registers RESET_VAL; out_valid=0, out_data=RESET_VAL, count=0, in_ready=1. Release is synchronous to the next clk edge.
- Stage i (0=input side, DEPTH-1=output side) holds v[i], d[i].
- Readiness:
  - rdy[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - rdy[i] = !v[i] | rdy[i+1].
  - in_ready = rdy[0] & !flush.
- Readiness is combinational from out_ready to in_ready (no skid). Bubbles collapse: an empty stage always accepts.
- On each edge, when rdy[i]=1:
  - v[i] <= upstream valid (in_valid & in_ready for stage 0; v[i-1] otherwise).
  - d[i] <= upstream data only when upstream valid=1. Data is held when a bubble moves in.
- When rdy[i]=0: stage holds v[i] and d[i].
- Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready.
- Latency: accepted word appears on out_valid exactly DEPTH cycles later when never stalled. Throughput is 1 word/cycle with out_ready held high.
- out_valid = v[DEPTH-1] & !flush; out_data = d[DEPTH-1] (unmasked).
- Flush (sync): next edge clears all v[i] and count. Data registers keep their values.
  - In the flush cycle no accept and no emit occurs (in_ready=0, out_valid=0), regardless of in_valid/out_ready.
  - Flush has priority over all movement.
- count: registered, equals the number of set v[i]. Next value = count + accept - emit, or 0 on flush. Range 0..DEPTH; never wraps.
- Full (count=DEPTH) with out_ready=0: in_ready=0, all stages hold.
- Full with out_ready=1: emit and accept in the same cycle, count unchanged.
- Empty: out_valid=0; out_data shows the stale last word.
- in_data is sampled only on accept. Changing it while in_ready=0 has no effect.
- Reset asserted mid-transfer: state clears immediately, independent of clk; the in-progress word is lost.
- DEPTH=1 degenerates to a single registered stage with backpressure. Its in_ready still depends combinationally on out_ready.

Decomposition:
- Shared package pipe_pkg:
  - CNT_W function (clog2(DEPTH+1)).
  - Default WIDTH constant (32) matching the processor word.
- Natural sub-module pipe_stage:
  - Parameters WIDTH and RESET_VAL.
  - Ports clk, reset, flush, up_valid, up_data, dn_ready, v, d, rdy.
- pipe_reg_chain instantiates DEPTH copies in a generate loop and owns the count register.

Test Plan:
1. Reset: hold reset=1 for 22 ns with clk toggling -> out_valid=0, count=0, out_data=0, in_ready=1. Repeat with RESET_VAL=32'hDEAD_BEEF -> out_data=DEADBEEF.
2. Streaming (DEPTH=2, out_ready=1): accept 12, 13, 14 on consecutive edges -> out_valid rises 2 cycles after the 12 accept; outputs are 12, 13, 14 on consecutive cycles; count peaks at 2.
3. Backpressure (DEPTH=3): out_ready=0, present 1..4 -> 1, 2, 3 accepted, count=3, in_ready=0, 4 held upstream. Raise out_ready -> 1, 2, 3, 4 emerge in order, none lost or duplicated.
4. Bubble collapse (DEPTH=3): accept 5, idle 1 cycle, accept 6, out_ready=0 -> after 3 cycles count=2; outputs are 5 then 6 with no gap once out_ready=1.
5. Flush: with count=2, in_valid=1, out_ready=1, pulse flush for 1 cycle -> that cycle in_ready=0 and out_valid=0; next cycle count=0 and out_valid=0; the following word 9 exits DEPTH cycles after its accept.
6. Async reset mid-stream: assert reset between clk edges while count=2 -> out_valid and count go to 0 before the next edge; after release, streaming resumes per scenario 2.

Source files
------------

// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants and helpers for the elastic pipeline register chain.
// Sizes the occupancy counter and fixes the default processor word width.
package pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One elastic register stage: a valid bit plus a data word.
// It accepts whenever it is empty or its own word leaves this cycle.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             rdy
);

    logic             v_q;
    logic             v_d;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_d;

    assign rdy = !v_q || dn_ready;

    // Flush only drops the valid bit; data keeps its value.
    // Bubbles move in without disturbing the held data.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (rdy) begin
            v_d = up_valid;
            if (up_valid) begin
                d_d = up_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= 1'b0;
            d_q <= RESET_VAL;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v = v_q;
    assign d = d_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-deep elastic pipeline register with valid/ready backpressure,
// synchronous flush and a registered occupancy count.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int CW = cnt_w(DEPTH);

    // Handshake: a word moves on an edge where valid and ready are both high.
    // Ready ripples combinationally from out_ready back to in_ready (no skid
    // buffer), and flush forces both in_ready and out_valid low.
    logic accept;
    logic emit;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             dn_ready;
        logic             v;
        logic [WIDTH-1:0] d;
        logic             rdy;

        if (i == 0) begin : g_head
            assign up_valid = accept;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = g_stage[i-1].v;
            assign up_data  = g_stage[i-1].d;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_ready = out_ready;
        end else begin : g_mid
            assign dn_ready = g_stage[i+1].rdy;
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .up_valid (up_valid),
            .up_data  (up_data),
            .dn_ready (dn_ready),
            .v        (v),
            .d        (d),
            .rdy      (rdy)
        );
    end

    assign in_ready  = g_stage[0].rdy && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = g_stage[DEPTH-1].v && !flush;
    assign out_data  = g_stage[DEPTH-1].d;
    assign emit      = out_valid && out_ready;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(accept) - CW'(emit);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: reset values, streaming, backpressure,
// bubble collapse, flush, async reset and the single-stage case.
module tb_pipe_reg_chain;

  logic clk;
  logic reset;

  // a: DEPTH=2, RESET_VAL=0
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_count;
  // b: DEPTH=3
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_count;
  // c: DEPTH=2, RESET_VAL=DEADBEEF
  logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [31:0] c_in_data, c_out_data;
  logic [1:0]  c_count;
  // d: DEPTH=1, WIDTH=8
  logic        d_flush, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [7:0]  d_in_data, d_out_data;
  logic [0:0]  d_count;

  logic [31:0] exp_q[$];
  int n_cmp;
  int n_bad;

  pipe_reg_chain #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'h0)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .count(a_count)
  );

  pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'h0)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .count(b_count)
  );

  pipe_reg_chain #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'hDEAD_BEEF)) u_c (
    .clk(clk), .reset(reset), .flush(c_flush), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .in_data(c_in_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .count(c_count)
  );

  pipe_reg_chain #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h0)) u_d (
    .clk(clk), .reset(reset), .flush(d_flush), .in_valid(d_in_valid),
    .in_ready(d_in_ready), .in_data(d_in_data), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .out_data(d_out_data), .count(d_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(negedge clk);
  endtask

  // Pops the next expected word and checks the emitted one against it.
  task automatic expect_out(input string tag, input logic [31:0] got);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_qempty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, got, e);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    {a_flush, a_in_valid, a_out_ready} = '0; a_in_data = '0;
    {b_flush, b_in_valid, b_out_ready} = '0; b_in_data = '0;
    {c_flush, c_in_valid, c_out_ready} = '0; c_in_data = '0;
    {d_flush, d_in_valid, d_out_ready} = '0; d_in_data = '0;

    // 1. reset
    #22;
    check("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_a_count", {30'd0, a_count}, 32'd0);
    check("rst_a_out_data", a_out_data, 32'd0);
    check("rst_a_in_ready", {31'd0, a_in_ready}, 32'd1);
    check("rst_c_out_data", c_out_data, 32'hDEAD_BEEF);
    check("rst_c_out_valid", {31'd0, c_out_valid}, 32'd0);
    tick(); reset = 1'b0;

    // 2. streaming, DEPTH=2
    tick(); a_in_valid = 1; a_in_data = 12; a_out_ready = 1; #1;
    check("st_in_ready", {31'd0, a_in_ready}, 32'd1);
    tick(); a_in_data = 13; #1;
    check("st_c1_valid", {31'd0, a_out_valid}, 32'd0);
    check("st_c1_count", {30'd0, a_count}, 32'd1);
    tick(); a_in_data = 14; #1;
    check("st_c2_valid", {31'd0, a_out_valid}, 32'd1);
    check("st_c2_data", a_out_data, 32'd12);
    check("st_c2_count", {30'd0, a_count}, 32'd2);
    tick(); a_in_valid = 0; #1;
    check("st_c3_data", a_out_data, 32'd13);
    check("st_c3_count", {30'd0, a_count}, 32'd2);
    tick(); #1;
    check("st_c4_valid", {31'd0, a_out_valid}, 32'd1);
    check("st_c4_data", a_out_data, 32'd14);
    check("st_c4_count", {30'd0, a_count}, 32'd1);
    tick(); #1;
    check("st_c5_valid", {31'd0, a_out_valid}, 32'd0);
    check("st_c5_count", {30'd0, a_count}, 32'd0);
    check("st_c5_stale", a_out_data, 32'd14);

    // 3. backpressure, DEPTH=3
    tick(); b_in_valid = 1; b_in_data = 1; b_out_ready = 0; #1;
    check("bp_rdy1", {31'd0, b_in_ready}, 32'd1); exp_q.push_back(32'd1);
    tick(); b_in_data = 2; #1;
    check("bp_rdy2", {31'd0, b_in_ready}, 32'd1); exp_q.push_back(32'd2);
    tick(); b_in_data = 3; #1;
    check("bp_rdy3", {31'd0, b_in_ready}, 32'd1); exp_q.push_back(32'd3);
    tick(); b_in_data = 4; #1;
    check("bp_full_rdy", {31'd0, b_in_ready}, 32'd0);
    check("bp_full_count", {30'd0, b_count}, 32'd3);
    check("bp_full_valid", {31'd0, b_out_valid}, 32'd1);
    tick(); b_in_data = 99; #1;
    check("bp_hold_rdy", {31'd0, b_in_ready}, 32'd0);
    check("bp_hold_count", {30'd0, b_count}, 32'd3);
    tick(); b_in_data = 4; b_out_ready = 1; #1;
    check("bp_release_rdy", {31'd0, b_in_ready}, 32'd1); exp_q.push_back(32'd4);
    expect_out("bp_out1", b_out_data);
    tick(); b_in_valid = 0; #1;
    check("bp_cnt_after_swap", {30'd0, b_count}, 32'd3);
    expect_out("bp_out2", b_out_data);
    tick(); #1; expect_out("bp_out3", b_out_data);
    tick(); #1; expect_out("bp_out4", b_out_data);
    check("bp_cnt_last", {30'd0, b_count}, 32'd1);
    tick(); #1;
    check("bp_drained_valid", {31'd0, b_out_valid}, 32'd0);
    check("bp_drained_count", {30'd0, b_count}, 32'd0);
    check("bp_no_extra", exp_q.size(), 32'd0);

    // 4. bubble collapse, DEPTH=3
    tick(); b_in_valid = 1; b_in_data = 5; b_out_ready = 0;
    tick(); b_in_valid = 0;
    tick(); b_in_valid = 1; b_in_data = 6;
    tick(); b_in_valid = 0; #1;
    check("bub_count", {30'd0, b_count}, 32'd2);
    tick(); #1;
    check("bub_out5_valid", {31'd0, b_out_valid}, 32'd1);
    check("bub_out5_data", b_out_data, 32'd5);
    check("bub_in_ready", {31'd0, b_in_ready}, 32'd1);
    b_out_ready = 1;
    tick(); #1;
    check("bub_out6_valid", {31'd0, b_out_valid}, 32'd1);
    check("bub_out6_data", b_out_data, 32'd6);
    tick(); #1;
    check("bub_empty", {31'd0, b_out_valid}, 32'd0);

    // 5. flush, DEPTH=2
    tick(); a_in_valid = 1; a_in_data = 20; a_out_ready = 0;
    tick(); a_in_data = 21;
    tick(); a_in_data = 22; a_flush = 1; a_out_ready = 1; #1;
    check("fl_pre_count", {30'd0, a_count}, 32'd2);
    check("fl_in_ready", {31'd0, a_in_ready}, 32'd0);
    check("fl_out_valid", {31'd0, a_out_valid}, 32'd0);
    tick(); a_flush = 0; a_in_data = 9; #1;
    check("fl_post_count", {30'd0, a_count}, 32'd0);
    check("fl_post_valid", {31'd0, a_out_valid}, 32'd0);
    check("fl_post_data", a_out_data, 32'd20);
    tick(); a_in_valid = 0; #1;
    check("fl_9_c1_valid", {31'd0, a_out_valid}, 32'd0);
    tick(); #1;
    check("fl_9_c2_valid", {31'd0, a_out_valid}, 32'd1);
    check("fl_9_c2_data", a_out_data, 32'd9);
    tick(); #1;
    check("fl_9_done", {30'd0, a_count}, 32'd0);

    // 6. async reset mid-stream, DEPTH=2
    tick(); a_in_valid = 1; a_in_data = 30; a_out_ready = 0;
    tick(); a_in_data = 31;
    tick(); a_in_valid = 0; #1;
    check("ar_pre_count", {30'd0, a_count}, 32'd2);
    #2 reset = 1'b1; #1;
    check("ar_valid", {31'd0, a_out_valid}, 32'd0);
    check("ar_count", {30'd0, a_count}, 32'd0);
    check("ar_data", a_out_data, 32'd0);
    tick(); reset = 1'b0;
    tick(); a_in_valid = 1; a_in_data = 40; a_out_ready = 1;
    tick(); a_in_data = 41; #1;
    check("ar_s_c1_valid", {31'd0, a_out_valid}, 32'd0);
    tick(); a_in_valid = 0; #1;
    check("ar_s_out40", a_out_data, 32'd40);
    check("ar_s_valid40", {31'd0, a_out_valid}, 32'd1);
    tick(); #1;
    check("ar_s_out41", a_out_data, 32'd41);
    tick(); #1;
    check("ar_s_done", {30'd0, a_count}, 32'd0);

    // DEPTH=1: ready still follows out_ready combinationally
    tick(); d_in_valid = 1; d_in_data = 8'd7; d_out_ready = 0; #1;
    check("d1_rdy_empty", {31'd0, d_in_ready}, 32'd1);
    tick(); d_in_data = 8'd8; #1;
    check("d1_rdy_full", {31'd0, d_in_ready}, 32'd0);
    check("d1_out7", {24'd0, d_out_data}, 32'd7);
    check("d1_count_full", {31'd0, d_count}, 32'd1);
    d_out_ready = 1; #1;
    check("d1_rdy_comb", {31'd0, d_in_ready}, 32'd1);
    tick(); d_in_valid = 0; #1;
    check("d1_out8", {24'd0, d_out_data}, 32'd8);
    check("d1_count_swap", {31'd0, d_count}, 32'd1);
    tick(); #1;
    check("d1_empty", {31'd0, d_out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
